branch_predictor: RTL and testbench

- Direct-mapped BTB plus 2-bit saturating-counter branch predictor for the RV32I pipeline.
- The IF stage supplies the fetch PC and receives a predicted-taken flag and target.
- The EX stage supplies the resolved outcome: the comparator's br_en plus the computed target.
- The block trains its tables from that outcome, produces the mispredict flush and redirect PC, and keeps performance counters.

---
 rtl/branch_predictor.sv | 140 ++++++++++++++
 tb/tb_branch_predictor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped BTB with 2-bit saturating direction counters.
//             Combinational lookup for IF, combinational mispredict/redirect
//             for EX, table training at the clock edge, and performance
//             counters for resolved branches and mispredictions.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int IDX_BITS = 6,
   parameter int TAG_BITS = 32 - IDX_BITS - 2
) (
   input  logic        clk,
   input  logic        rst_n,
   // fetch-side lookup
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target,
   // execute-side resolution
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   // performance counters
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int         c_entries   = 1 << IDX_BITS;
   localparam logic [1:0] c_ctr_snt   = 2'b00;
   localparam logic [1:0] c_ctr_wt    = 2'b10;
   localparam logic [1:0] c_ctr_st    = 2'b11;

   // Table storage. Only valid and ctr are reset; tag/target are qualified
   // by valid everywhere they are used.
   logic [c_entries-1:0] r_valid;
   logic [TAG_BITS-1:0]  r_tag    [c_entries];
   logic [31:0]          r_target [c_entries];
   logic [1:0]           r_ctr    [c_entries];

   logic [31:0]          r_branch_count;
   logic [31:0]          r_mispredict_count;

   // Lookup/update address decode
   logic [IDX_BITS-1:0]  w_if_idx;
   logic [TAG_BITS-1:0]  w_if_tag;
   logic                 w_if_hit;
   logic [IDX_BITS-1:0]  w_ex_idx;
   logic [TAG_BITS-1:0]  w_ex_tag;
   logic                 w_ex_hit;
   logic                 w_mispredict;

   // Byte-offset bits of the PCs carry no information for word-aligned fetch.
   logic                 w_unused_pc_bits;
   assign w_unused_pc_bits = &{1'b0, if_pc[1:0], ex_pc[1:0]};

   assign w_if_idx = if_pc[IDX_BITS+1:2];
   assign w_if_tag = if_pc[31:IDX_BITS+2];
   assign w_ex_idx = ex_pc[IDX_BITS+1:2];
   assign w_ex_tag = ex_pc[31:IDX_BITS+2];

   // Lookup reads the registered table directly, so a same-cycle update is
   // not bypassed; a cleared valid bit masks any stale tag/target contents.
   always_comb begin
      w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
      if_pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
      if_pred_target = w_if_hit ? r_target[w_if_idx] : 32'd0;
   end

   // Resolution: compare the travelling prediction with the real outcome.
   always_comb begin
      w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
      w_mispredict = ex_valid &&
                     ((ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_pred_target != ex_target)));
      mispredict   = w_mispredict;
      if (!ex_valid) begin
         redirect_pc = 32'd0;
      end else if (ex_taken) begin
         redirect_pc = ex_target;
      end else begin
         redirect_pc = ex_pc + 32'd4;
      end
   end

   // Valid bits and direction counters: cleared by reset, trained by EX.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_ctr   <= '{default: c_ctr_snt};
      end else if (ex_valid) begin
         if (w_ex_hit) begin
            if (ex_taken) begin
               if (r_ctr[w_ex_idx] != c_ctr_st) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
               end
            end else begin
               if (r_ctr[w_ex_idx] != c_ctr_snt) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
               end
            end
         end else if (ex_taken) begin
            r_valid[w_ex_idx] <= 1'b1;
            r_ctr[w_ex_idx]   <= c_ctr_wt;
         end
      end
   end

   // Tag and target payload: written on any taken resolution (hit refreshes
   // the target with an identical tag, miss allocates or evicts).
   always_ff @(posedge clk) begin
      if (rst_n && ex_valid && ex_taken) begin
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= ex_target;
      end
   end

   // Performance counters, free-running modulo 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_branch_count     <= 32'd0;
         r_mispredict_count <= 32'd0;
      end else if (ex_valid) begin
         r_branch_count <= r_branch_count + 32'd1;
         if (w_mispredict) begin
            r_mispredict_count <= r_mispredict_count + 32'd1;
         end
      end
   end

   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor
//  Purpose  : Self-checking bench for branch_predictor: directed scenarios
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int vectors;
   int miscompares;

   branch_predictor dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .if_pred_target   (if_pred_target),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: one record per table slot, counter as plain 0..3.
   typedef struct {
      bit          valid;
      logic [31:0] tag;
      logic [31:0] target;
      int          ctr;
   } entry_t;

   entry_t      m_tab [64];
   logic [31:0] m_bcnt;
   logic [31:0] m_mcnt;

   // Outputs captured during the most recent cycle.
   logic        obs_pt;
   logic [31:0] obs_ptgt;
   logic        obs_mp;
   logic [31:0] obs_rd;

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc / 32'd4) % 32'd64);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc / 32'd256;
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_tab[slot_of(pc)].valid && (m_tab[slot_of(pc)].tag == tag_of(pc));
   endfunction

   function automatic bit m_pred_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_tab[slot_of(pc)].ctr >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
      return m_hit(pc) ? m_tab[slot_of(pc)].target : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 64; i++) begin
         m_tab[i].valid = 1'b0;
         m_tab[i].ctr   = 0;
      end
      m_bcnt = 32'd0;
      m_mcnt = 32'd0;
   endtask

   // One clock cycle: drive, check combinational outputs, then train model.
   task automatic do_cycle(input bit rst, input bit exv, input logic [31:0] expc,
                           input bit ext, input logic [31:0] extgt,
                           input bit expt, input logic [31:0] exptgt,
                           input logic [31:0] ifpc);
      bit          e_mp;
      logic [31:0] e_rd;
      int          s;
      @(negedge clk);
      rst_n          = rst;
      ex_valid       = exv;
      ex_pc          = expc;
      ex_taken       = ext;
      ex_target      = extgt;
      ex_pred_taken  = expt;
      ex_pred_target = exptgt;
      if_pc          = ifpc;
      #1;
      e_mp = exv && ((ext != expt) || (ext && (exptgt != extgt)));
      e_rd = !exv ? 32'd0 : (ext ? extgt : expc + 32'd4);
      chk("pred_taken",  {31'd0, if_pred_taken}, {31'd0, m_pred_taken(ifpc)});
      chk("pred_target", if_pred_target, m_pred_target(ifpc));
      chk("mispredict",  {31'd0, mispredict}, {31'd0, e_mp});
      chk("redirect_pc", redirect_pc, e_rd);
      chk("branch_cnt",  branch_count, m_bcnt);
      chk("mispred_cnt", mispredict_count, m_mcnt);
      obs_pt   = if_pred_taken;
      obs_ptgt = if_pred_target;
      obs_mp   = mispredict;
      obs_rd   = redirect_pc;
      @(posedge clk);
      if (!rst) begin
         m_reset();
      end else if (exv) begin
         m_bcnt = m_bcnt + 32'd1;
         if (e_mp) m_mcnt = m_mcnt + 32'd1;
         s = slot_of(expc);
         if (m_hit(expc)) begin
            if (ext) begin
               m_tab[s].ctr    = (m_tab[s].ctr + 1 > 3) ? 3 : m_tab[s].ctr + 1;
               m_tab[s].target = extgt;
            end else begin
               m_tab[s].ctr = (m_tab[s].ctr - 1 < 0) ? 0 : m_tab[s].ctr - 1;
            end
         end else if (ext) begin
            m_tab[s].valid  = 1'b1;
            m_tab[s].tag    = tag_of(expc);
            m_tab[s].target = extgt;
            m_tab[s].ctr    = 2;
         end
      end
   endtask

   task automatic idle(input logic [31:0] ifpc);
      do_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, ifpc);
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] tgt;
      bit          tk;
      bit          pt;
      logic [31:0] ptg;

      vectors     = 0;
      miscompares = 0;
      m_reset();

      // Initial reset edge before anything is observed.
      rst_n = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
      ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; if_pc = '0;
      @(posedge clk);

      // Reset state
      idle(32'h40);
      chk("rst_lookup_40", {31'd0, obs_pt}, 32'd0);
      idle(32'h1040);
      chk("rst_lookup_1040", {31'd0, obs_pt}, 32'd0);

      // Cold taken branch
      do_cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
      chk("cold_mispredict", {31'd0, obs_mp}, 32'd1);
      chk("cold_redirect", obs_rd, 32'h80);
      idle(32'h40);
      chk("cold_pred", {31'd0, obs_pt}, 32'd1);
      chk("cold_target", obs_ptgt, 32'h80);

      // Hysteresis
      do_cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 32'h40);
      do_cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 32'h40);
      chk("hyst_no_mispredict", {31'd0, obs_mp}, 32'd0);
      do_cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 32'h40);
      chk("hyst_nt_redirect", obs_rd, 32'h44);
      idle(32'h40);
      chk("hyst_still_taken", {31'd0, obs_pt}, 32'd1);
      do_cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 32'h40);
      idle(32'h40);
      chk("hyst_now_nt", {31'd0, obs_pt}, 32'd0);

      // Alias at the same index
      idle(32'h1040);
      do_cycle(1'b1, 1'b1, 32'h1040, 1'b1, 32'h2000, 1'b0, 32'h0, 32'h1040);
      idle(32'h40);
      chk("alias_evicted", {31'd0, obs_pt}, 32'd0);
      idle(32'h1040);
      chk("alias_target", obs_ptgt, 32'h2000);

      // Same-cycle collision: no bypass
      do_cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 32'h40);
      chk("collide_same", {31'd0, obs_pt}, 32'd0);
      idle(32'h40);
      chk("collide_next", {31'd0, obs_pt}, 32'd1);

      // Target change, then reset together with an update
      do_cycle(1'b1, 1'b1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80, 32'h40);
      chk("tchg_redirect", obs_rd, 32'h90);
      idle(32'h40);
      chk("tchg_target", obs_ptgt, 32'h90);
      do_cycle(1'b0, 1'b1, 32'h40, 1'b1, 32'ha0, 1'b1, 32'h90, 32'h40);
      idle(32'h40);
      chk("post_rst_empty", {31'd0, obs_pt}, 32'd0);

      // Randomized traffic over a small PC space so entries collide often.
      for (int n = 0; n < 400; n++) begin
         pc  = ($urandom_range(0, 3) * 32'h100) + ($urandom_range(0, 7) * 32'd4);
         tgt = {$urandom_range(0, 15), 2'b00} + 32'h100;
         tk  = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 9) < 7) begin
            pt  = m_pred_taken(pc);
            ptg = m_pred_target(pc);
         end else begin
            pt  = $urandom_range(0, 1) == 1;
            ptg = {$urandom_range(0, 15), 2'b00} + 32'h100;
         end
         do_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), pc, tk, tgt, pt, ptg,
                  ($urandom_range(0, 3) * 32'h100) + ($urandom_range(0, 7) * 32'd4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
